// File: rtl/rnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rnn_pkg
// Purpose  : Shared types and constants for the RNN hidden-state drain stage.
//            The result tag is {t[10:0], h[5:0]}, and data is signed Q3.16.
// Revision : 1.0 - initial release
// ============================================================================
package rnn_pkg;

  localparam int H_DIM = 64;
  localparam int T_W   = 11;
  localparam int H_W   = 6;
  localparam int D_W   = 20;
  localparam int E_W   = D_W + T_W + H_W;

  localparam logic [2:0]     MSEL_WR_H = 3'b101;
  localparam logic [D_W-1:0] Q_ONE     = 20'h10000;
  localparam logic [H_W-1:0] H_LAST    = 6'(H_DIM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // One buffered hidden-state word with its tags.
  typedef struct packed {
    logic [D_W-1:0] data;
    logic [T_W-1:0] t;
    logic [H_W-1:0] h;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/rnn_hstate_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : rnn_hstate_drain_if
// Purpose  : Valid/ready output stream carrying tagged hidden-state words.
//   o_valid  word available (driven by master)
//   o_ready  consumer accepts (driven by slave)
//   o_data   20-bit hidden value, o_t timestep tag, o_h neuron index
//   o_last   final word of the timestep (o_h == 63)
// Revision : 1.0 - initial release
// ============================================================================
interface rnn_hstate_drain_if;
  import rnn_pkg::*;

  logic           o_valid;
  logic           o_ready;
  logic [D_W-1:0] o_data;
  logic [T_W-1:0] o_t;
  logic [H_W-1:0] o_h;
  logic           o_last;

  modport master (output o_valid, o_data, o_t, o_h, o_last, input o_ready);
  modport slave  (input o_valid, o_data, o_t, o_h, o_last, output o_ready);

endinterface
`default_nettype wire

// File: rtl/rnn_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rnn_sync_fifo
// Purpose  : First-word-fall-through synchronous FIFO.
//   clk, reset (async, active-low), i_clr (sync clear, beats push/pop)
//   i_push/i_wdata write side, i_pop read side, o_rdata head word
//   (zero while empty), o_full / o_empty status flags.
// Revision : 1.0 - initial release
// ============================================================================
module rnn_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 37,
  parameter int AW    = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_clr,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_pop;
  logic             w_do_push;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty && !i_clr;
  // A push into a full FIFO lands in the slot the same-cycle pop vacates.
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_clr;

  // Head is masked while empty so stale storage never reaches the outputs.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rnn_hstate_drain.sv
`default_nettype none
// ============================================================================
// Module   : rnn_hstate_drain
// Purpose  : Snoops the RNN core result-write port, buffers hidden-state
//            words with {t,h} tags and streams them to the host/DMA.
//   clk, reset (async active-low), clr (sync soft clear)
//   mce/msel/maddr/mdata_w  core write port (msel 3'b101 = hidden write)
//   rnn_busy                core busy, falling edge starts the drain
//   out_if (master)         valid/ready word stream
//   o_eos                   one-cycle end-of-sequence pulse
//   t_done, ovf, seq_err, drop_cnt   status/error counters
//   max_vld/max_val/max_idx per-timestep max (RNN_HDRAIN_MAX_EN only)
// Build option: define RNN_HDRAIN_MAX_EN to build the max tracker.
// Revision : 1.0 - initial release
// ============================================================================
module rnn_hstate_drain
  import rnn_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DROP_W = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              mce,
  input  wire logic [2:0]        msel,
  input  wire logic [16:0]       maddr,
  input  wire logic [D_W-1:0]    mdata_w,
  input  wire logic              rnn_busy,
  input  wire logic              clr,
  rnn_hstate_drain_if.master     out_if,
  output logic                   o_eos,
  output logic      [T_W-1:0]    t_done,
  output logic                   ovf,
  output logic                   seq_err,
  output logic      [DROP_W-1:0] drop_cnt,
  output logic                   max_vld,
  output logic      [D_W-1:0]    max_val,
  output logic      [H_W-1:0]    max_idx
);

  logic           w_wr, w_pop, w_push, w_drop, w_full, w_empty;
  logic [H_W-1:0] w_h;
  entry_t         w_wentry, w_rentry;

  logic [H_W-1:0]    r_exp_h;
  logic [T_W-1:0]    r_t_done;
  logic              r_ovf, r_seq_err, r_busy_d, r_eos;
  logic [DROP_W-1:0] r_drop_cnt;
  state_t            r_state;

  assign w_wr   = mce && (msel == MSEL_WR_H);
  assign w_h    = maddr[H_W-1:0];
  assign w_pop  = out_if.o_valid && out_if.o_ready;
  assign w_push = w_wr && (!w_full || w_pop);
  assign w_drop = w_wr && w_full && !w_pop;

  assign w_wentry = '{data: mdata_w, t: maddr[16:H_W], h: w_h};

  rnn_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (E_W),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_rentry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_if.o_valid = !w_empty;
  assign out_if.o_data  = w_rentry.data;
  assign out_if.o_t     = w_rentry.t;
  assign out_if.o_h     = w_rentry.h;
  assign out_if.o_last  = (w_rentry.h == H_LAST);

  assign o_eos    = r_eos;
  assign t_done   = r_t_done;
  assign ovf      = r_ovf;
  assign seq_err  = r_seq_err;
  assign drop_cnt = r_drop_cnt;

  // Sequence checker and counters. Dropped words still advance the
  // expected index and the timestep count so the host view stays aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp_h    <= '0;
      r_t_done   <= '0;
      r_ovf      <= 1'b0;
      r_seq_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr) begin
      r_exp_h    <= '0;
      r_t_done   <= '0;
      r_ovf      <= 1'b0;
      r_seq_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_exp_h <= w_h + 6'd1;
        if (w_h == H_LAST) r_t_done <= r_t_done + 11'd1;
      end
      if (w_push && (w_h != r_exp_h)) r_seq_err <= 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  // Sequence FSM. o_eos is a registered pulse on the DRAIN->IDLE step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_busy_d <= 1'b0;
      r_eos    <= 1'b0;
    end else if (clr) begin
      r_state  <= IDLE;
      r_busy_d <= 1'b0;
      r_eos    <= 1'b0;
    end else begin
      r_busy_d <= rnn_busy;
      r_eos    <= 1'b0;
      case (r_state)
        IDLE:    if (w_wr) r_state <= ACTIVE;
        ACTIVE:  if (r_busy_d && !rnn_busy) r_state <= DRAIN;
        // A write arriving while empty keeps us draining one more round.
        DRAIN: begin
          if (w_empty && !w_push) begin
            r_state <= IDLE;
            r_eos   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RNN_HDRAIN_MAX_EN
  logic [D_W-1:0] r_run_max, r_max_val, w_cand_max;
  logic [H_W-1:0] r_run_idx, r_max_idx, w_cand_idx;
  logic           r_max_vld, w_take;

  // h==0 restarts the timestep; strict compare keeps the lower index on ties.
  assign w_take     = (w_h == '0) || ($signed(mdata_w) > $signed(r_run_max));
  assign w_cand_max = w_take ? mdata_w : r_run_max;
  assign w_cand_idx = w_take ? w_h : r_run_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run_max <= '0;
      r_run_idx <= '0;
      r_max_vld <= 1'b0;
      r_max_val <= '0;
      r_max_idx <= '0;
    end else if (clr) begin
      r_run_max <= '0;
      r_run_idx <= '0;
      r_max_vld <= 1'b0;
      r_max_val <= '0;
      r_max_idx <= '0;
    end else begin
      r_max_vld <= 1'b0;
      if (w_wr) begin
        r_run_max <= w_cand_max;
        r_run_idx <= w_cand_idx;
        if (w_h == H_LAST) begin
          r_max_vld <= 1'b1;
          r_max_val <= w_cand_max;
          r_max_idx <= w_cand_idx;
        end
      end
    end
  end

  assign max_vld = r_max_vld;
  assign max_val = r_max_val;
  assign max_idx = r_max_idx;
`else
  assign max_vld = 1'b0;
  assign max_val = '0;
  assign max_idx = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rnn_hstate_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_rnn_hstate_drain
// Purpose  : Directed self-checking bench for rnn_hstate_drain with a
//            scoreboard queue modelling FIFO contents and stream order.
//            Define RNN_HDRAIN_MAX_EN to also exercise the max tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rnn_hstate_drain;
  import rnn_pkg::*;

  logic           clk = 1'b0;
  logic           reset, mce, clr, rnn_busy;
  logic [2:0]     msel;
  logic [16:0]    maddr;
  logic [D_W-1:0] mdata_w;
  logic           o_eos, ovf, seq_err, max_vld;
  logic [T_W-1:0] t_done;
  logic [7:0]     drop_cnt;
  logic [D_W-1:0] max_val;
  logic [H_W-1:0] max_idx;

  rnn_hstate_drain_if bus ();

  rnn_hstate_drain #(.DEPTH(16), .AW(4), .DROP_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .mce      (mce),
    .msel     (msel),
    .maddr    (maddr),
    .mdata_w  (mdata_w),
    .rnn_busy (rnn_busy),
    .clr      (clr),
    .out_if   (bus),
    .o_eos    (o_eos),
    .t_done   (t_done),
    .ovf      (ovf),
    .seq_err  (seq_err),
    .drop_cnt (drop_cnt),
    .max_vld  (max_vld),
    .max_val  (max_val),
    .max_idx  (max_idx)
  );

  always #5 clk = ~clk;

  entry_t sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     n_pop = 0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: predicts pops/pushes from the inputs seen at each negedge,
  // which are exactly what the following rising edge samples.
  task automatic monitor();
    entry_t e;
    bit     pop;
    int     occ;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb_q.delete();
      end else begin
        occ = sb_q.size();
        chk("o_valid", 40'(bus.o_valid), 40'(occ != 0));
        if (clr) begin
          sb_q.delete();
        end else begin
          pop = bus.o_ready && (occ != 0);
          if (pop) begin
            e = sb_q.pop_front();
            n_pop++;
            chk("o_data", 40'(bus.o_data), 40'(e.data));
            chk("o_t",    40'(bus.o_t),    40'(e.t));
            chk("o_h",    40'(bus.o_h),    40'(e.h));
            chk("o_last", 40'(bus.o_last), 40'(e.h == 6'd63));
          end
          if (mce && (msel == 3'b101) && (occ < 16 || pop)) begin
            e.data = mdata_w;
            e.t    = maddr[16:6];
            e.h    = maddr[5:0];
            sb_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int t, input int h, input logic [19:0] d);
    mce     = 1'b1;
    msel    = 3'b101;
    maddr   = {11'(t), 6'(h)};
    mdata_w = d;
    tick(1);
    mce  = 1'b0;
    msel = 3'b000;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    int p0;
    int eos_at;
    logic saw;

    reset = 1'b0; mce = 1'b0; clr = 1'b0; rnn_busy = 1'b0;
    msel = '0; maddr = '0; mdata_w = '0; bus.o_ready = 1'b0;
    fork monitor(); join_none

    // Reset state
    tick(3);
    chk("rst_valid",  40'(bus.o_valid), 40'd0);
    chk("rst_t_done", 40'(t_done), 40'd0);
    chk("rst_ovf",    40'(ovf), 40'd0);
    chk("rst_seq",    40'(seq_err), 40'd0);
    chk("rst_drop",   40'(drop_cnt), 40'd0);
    chk("rst_eos",    40'(o_eos), 40'd0);
    chk("rst_data",   40'(bus.o_data), 40'd0);
    reset = 1'b1;
    tick(1);

    // 1: full timestep streamed with o_ready high
    rnn_busy = 1'b1;
    bus.o_ready = 1'b1;
    p0 = n_pop;
    for (int h = 0; h < 64; h++) wr(0, h, 20'(h << 12));
`ifndef RNN_HDRAIN_MAX_EN
    chk("max_vld_off", 40'(max_vld), 40'd0);
    chk("max_val_off", 40'(max_val), 40'd0);
`endif
    tick(3);
    chk("t1_pops",   40'(n_pop - p0), 40'd64);
    chk("t1_t_done", 40'(t_done), 40'd1);
    chk("t1_seq",    40'(seq_err), 40'd0);
    chk("t1_ovf",    40'(ovf), 40'd0);

    // 2: backpressure, 20 writes into a 16-deep FIFO
    do_clr();
    chk("clr_t_done", 40'(t_done), 40'd0);
    bus.o_ready = 1'b0;
    for (int h = 0; h < 20; h++) wr(1, h, Q_ONE + 20'(h));
    chk("t2_ovf",  40'(ovf), 40'd1);
    chk("t2_drop", 40'(drop_cnt), 40'd4);
    chk("t2_seq",  40'(seq_err), 40'd0);
    p0 = n_pop;
    bus.o_ready = 1'b1;
    tick(20);
    chk("t2_pops", 40'(n_pop - p0), 40'd16);

    // 3: write into a full FIFO during a pop is accepted
    do_clr();
    chk("clr_drop", 40'(drop_cnt), 40'd0);
    chk("clr_ovf",  40'(ovf), 40'd0);
    bus.o_ready = 1'b0;
    for (int h = 0; h < 16; h++) wr(2, h, 20'(h * 3));
    chk("t3_fill_drop", 40'(drop_cnt), 40'd0);
    bus.o_ready = 1'b1;
    wr(2, 16, 20'h12345);
    bus.o_ready = 1'b0;
    chk("t3_pop_drop", 40'(drop_cnt), 40'd0);
    chk("t3_pop_ovf",  40'(ovf), 40'd0);
    wr(2, 17, 20'h54321);   // still full: must drop
    chk("t3_full_drop", 40'(drop_cnt), 40'd1);
    p0 = n_pop;
    bus.o_ready = 1'b1;
    tick(20);
    chk("t3_pops", 40'(n_pop - p0), 40'd16);

    // 4: ordering error and resync
    do_clr();
    wr(3, 0, 20'h1);
    wr(3, 1, 20'h2);
    chk("t4_seq_ok", 40'(seq_err), 40'd0);
    wr(3, 3, 20'h3);
    chk("t4_seq_err", 40'(seq_err), 40'd1);
    wr(3, 4, 20'h4);
    chk("t4_seq_sticky", 40'(seq_err), 40'd1);
    tick(3);

    // 5: end of sequence after two timesteps and 5 queued words
    do_clr();
    for (int t = 0; t < 2; t++)
      for (int h = 0; h < 64; h++) wr(t, h, 20'(t * 64 + h));
    tick(2);
    bus.o_ready = 1'b0;
    for (int h = 0; h < 5; h++) wr(2, h, 20'hABC00 + 20'(h));
    chk("t5_t_done", 40'(t_done), 40'd2);
    rnn_busy = 1'b0;
    tick(1);
    bus.o_ready = 1'b1;
    eos_at = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      if (o_eos) begin
        eos_at = c;
        break;
      end
    end
    chk("t5_eos_cycle", 40'(eos_at), 40'd6);
    tick(1);
    chk("t5_eos_pulse", 40'(o_eos), 40'd0);
    chk("t5_t_done2",   40'(t_done), 40'd2);
    // Busy falling while IDLE must not raise o_eos
    rnn_busy = 1'b1;
    tick(2);
    rnn_busy = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      saw = saw | o_eos;
    end
    chk("t5_idle_no_eos", 40'(saw), 40'd0);

    // 6: per-timestep max
    do_clr();
    rnn_busy = 1'b1;
    for (int h = 0; h < 64; h++)
      wr(4, h, (h == 17 || h == 40) ? 20'h08000 : 20'hf0000);
`ifdef RNN_HDRAIN_MAX_EN
    chk("t6_max_vld", 40'(max_vld), 40'd1);
    chk("t6_max_val", 40'(max_val), 40'h08000);
    chk("t6_max_idx", 40'(max_idx), 40'd17);
    tick(1);
    chk("t6_max_pulse", 40'(max_vld), 40'd0);
`else
    chk("t6_max_vld_off", 40'(max_vld), 40'd0);
    chk("t6_max_idx_off", 40'(max_idx), 40'd0);
`endif
    tick(3);

    // Reset asserted mid-burst
    bus.o_ready = 1'b0;
    for (int h = 0; h < 18; h++) wr(5, h, 20'(h + 7));
    chk("t7_pre_drop",   40'(drop_cnt), 40'd2);
    chk("t7_pre_t_done", 40'(t_done), 40'd1);
    #2 reset = 1'b0;
    #1;
    chk("t7_valid", 40'(bus.o_valid), 40'd0);
    chk("t7_t_done", 40'(t_done), 40'd0);
    chk("t7_drop",  40'(drop_cnt), 40'd0);
    chk("t7_ovf",   40'(ovf), 40'd0);
    chk("t7_data",  40'(bus.o_data), 40'd0);
    tick(1);
    reset = 1'b1;
    tick(2);
    chk("t7_valid_after", 40'(bus.o_valid), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
